// File: rtl/cu_mem_pkg.sv
// Shared definitions for the control-unit memory requester:
// RV32 load/store funct3 encodings and the request FSM states.
package cu_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/cu_mem_lane_align.sv
// Byte-lane steering for the memory requester: byte enables, store
// replication, misalignment/illegal detect and load extract/extend.
module cu_mem_lane_align
    import cu_mem_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  bytesel_o,
    output logic [31:0] wdata_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic        illegal;
    logic        misal;
    logic [31:0] shifted;

    always_comb begin
        is_b    = 1'b0;
        is_h    = 1'b0;
        is_w    = 1'b0;
        illegal = 1'b0;
        case (funct3_i)
            F3_LB, F3_LBU: is_b = 1'b1;
            F3_LH, F3_LHU: is_h = 1'b1;
            F3_LW:         is_w = 1'b1;
            default:       illegal = 1'b1;
        endcase
        // Unsigned variants only exist for loads.
        if (is_store_i && funct3_i[2]) begin
            illegal = 1'b1;
        end
    end

    assign misal = (is_h && addr_lo_i[0]) || (is_w && (addr_lo_i != 2'b00));
    assign err_o = illegal || misal;

    always_comb begin
        bytesel_o = 4'b0000;
        wdata_o   = wdata_i;
        if (is_b) begin
            bytesel_o = 4'b0001 << addr_lo_i;
            wdata_o   = {4{wdata_i[7:0]}};
        end else if (is_h) begin
            bytesel_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o   = {2{wdata_i[15:0]}};
        end else if (is_w) begin
            bytesel_o = 4'b1111;
        end
    end

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        rdata_o = 32'h0;
        case (funct3_i)
            F3_LB:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  rdata_o = {24'h0, shifted[7:0]};
            F3_LH:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  rdata_o = {16'h0, shifted[15:0]};
            F3_LW:   rdata_o = shifted;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/cu_mem_requester.sv
// Control-unit initiator for the MMU port: one load/store per handshake,
// single-cycle retrieve pulse, fixed-latency wait, single-cycle response.
module cu_mem_requester
    import cu_mem_pkg::*;
#(
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_LAT = 1
) (
    input  logic        soc_clk,
    input  logic        soc_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] CU_address,
    output logic [3:0]  CU_bytesel,
    output logic [31:0] CU_dat_in,
    output logic        read_or_write,
    output logic        retrieve,
    input  logic [31:0] MMU_dat_out,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int CW = 8;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic        err_q, err_d;
    logic        rw_q, rw_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  bytesel_q, bytesel_d;
    logic [31:0] datin_q, datin_d;
    logic [31:0] rdata_q, rdata_d;

    logic        idle;
    logic        al_store;
    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [3:0]  al_bytesel;
    logic [31:0] al_wdata;
    logic        al_err;
    logic [31:0] al_rdata;

    assign idle = (state_q == ST_IDLE);

    // Live request fields steer lanes at accept; latched ones at capture.
    assign al_store = idle ? req_is_store : rw_q;
    assign al_f3    = idle ? req_funct3 : f3_q;
    assign al_lo    = idle ? req_addr[1:0] : addr_q[1:0];

    cu_mem_lane_align u_align (
        .is_store_i (al_store),
        .funct3_i   (al_f3),
        .addr_lo_i  (al_lo),
        .wdata_i    (req_wdata),
        .rdata_i    (MMU_dat_out),
        .bytesel_o  (al_bytesel),
        .wdata_o    (al_wdata),
        .err_o      (al_err),
        .rdata_o    (al_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        err_d     = err_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        bytesel_d = bytesel_q;
        datin_d   = datin_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    f3_d      = req_funct3;
                    err_d     = al_err;
                    rw_d      = req_is_store;
                    addr_d    = req_addr;
                    bytesel_d = al_bytesel;
                    datin_d   = al_wdata;
                    rdata_d   = 32'h0;
                    state_d   = al_err ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = rw_q ? CW'(WRITE_LAT - 1) : CW'(READ_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (!rw_q) begin
                        rdata_d = al_rdata;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge soc_clk or posedge soc_rst) begin
        if (soc_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            f3_q      <= 3'b000;
            err_q     <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= 32'h0;
            bytesel_q <= 4'b0000;
            datin_q   <= 32'h0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            err_q     <= err_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            bytesel_q <= bytesel_d;
            datin_q   <= datin_d;
            rdata_q   <= rdata_d;
        end
    end

    assign req_ready     = idle;
    assign retrieve      = (state_q == ST_ISSUE);
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_err      = resp_valid && err_q;
    assign resp_rdata    = rdata_q;
    assign CU_address    = addr_q;
    assign CU_bytesel    = bytesel_q;
    assign CU_dat_in     = datin_q;
    assign read_or_write = rw_q;

endmodule
